// File: rtl/alu_share_ctrl_if.sv
// Request, ALU and response signals shared between the two requesters,
// the response consumer, the shared ALU and the sharing controller.
interface alu_share_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) ();

    logic             req0;
    logic [OPW-1:0]   op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [OPW-1:0]   op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;
    logic             busy;

    // Controller view
    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_result, rsp_ready,
        output gnt0, gnt1, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_id, busy
    );

    // Requesters, ALU and consumer view
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_result, rsp_ready,
        input  gnt0, gnt1, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Round-robin grant in
// IDLE, one EXEC cycle with registered ALU inputs, then the captured result is
// held in RESP until the consumer takes it.
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input logic             clock,
    input logic             reset,
    alu_share_ctrl_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic             owner_q, owner_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             gnt0, gnt1;

    // Grant decode and next-state logic
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        owner_d     = owner_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On contention the requester that did not win last time goes first
                if (!reset) begin
                    gnt0 = bus_io.req0 && (!bus_io.req1 || last_gnt_q);
                    gnt1 = bus_io.req1 && !gnt0;
                end
                if (gnt0) begin
                    alu_op_d = bus_io.op0;
                    alu_a_d  = bus_io.a0;
                    alu_b_d  = bus_io.b0;
                    owner_d  = 1'b0;
                    state_d  = StExec;
                end else if (gnt1) begin
                    alu_op_d = bus_io.op1;
                    alu_a_d  = bus_io.a1;
                    alu_b_d  = bus_io.b1;
                    owner_d  = 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = bus_io.alu_result;
                rsp_id_d    = owner_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_gnt_d  = owner_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            last_gnt_q  <= 1'b1;
            owner_q     <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus_io.gnt0      = gnt0;
    assign bus_io.gnt1      = gnt1;
    assign bus_io.alu_op    = alu_op_q;
    assign bus_io.alu_a     = alu_a_q;
    assign bus_io.alu_b     = alu_b_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_data  = rsp_data_q;
    assign bus_io.rsp_id    = rsp_id_q;
    assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU attached.
module tb_alu_share_ctrl;

    localparam logic [2:0] OpAnd = 3'd0;
    localparam logic [2:0] OpOr  = 3'd1;
    localparam logic [2:0] OpXor = 3'd2;
    localparam logic [2:0] OpAdd = 3'd3;
    localparam logic [2:0] OpSub = 3'd4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_share_ctrl_if #(.WIDTH(32), .OPW(3)) bus ();

    alu_share_ctrl #(.WIDTH(32), .OPW(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    // Shared ALU
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            OpAnd:   bus.alu_result = bus.alu_a & bus.alu_b;
            OpOr:    bus.alu_result = bus.alu_a | bus.alu_b;
            OpXor:   bus.alu_result = bus.alu_a ^ bus.alu_b;
            OpAdd:   bus.alu_result = bus.alu_a + bus.alu_b;
            OpSub:   bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++;
            $display("FAIL reset_gnt got %b%b want 00", bus.gnt0, bus.gnt1); end
        n_checks++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin n_fail++;
            $display("FAIL reset_alu_ab got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
        n_checks++; if (bus.alu_op !== 3'd0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 1'b0)
            begin n_fail++;
            $display("FAIL reset_regs got op %0d data %h id %b want 0/0/0",
                     bus.alu_op, bus.rsp_data, bus.rsp_id); end
    endtask

    task automatic test_single_op();
        bus.req0 = 1'b1; bus.op0 = OpOr; bus.a0 = 32'hF0F0_0000; bus.b0 = 32'h0000_0F0F;
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++;
            $display("FAIL single_gnt got %b%b want 10", bus.gnt0, bus.gnt1); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL single_busy_c0 got %b want 0", bus.busy); end
        @(negedge clock);
        bus.req0 = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b1 || bus.gnt0 !== 1'b0) begin n_fail++;
            $display("FAIL single_exec got busy %b gnt0 %b want 1/0", bus.busy, bus.gnt0); end
        n_checks++; if (bus.alu_op !== OpOr || bus.alu_a !== 32'hF0F0_0000 ||
                        bus.alu_b !== 32'h0000_0F0F) begin n_fail++;
            $display("FAIL single_alu_regs got %0d %h %h want 1 f0f00000 00000f0f",
                     bus.alu_op, bus.alu_a, bus.alu_b); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_valid_c1 got %b want 0", bus.rsp_valid); end
        @(negedge clock);
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++;
            $display("FAIL single_valid_c2 got %b want 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 32'hF0F0_0F0F || bus.rsp_id !== 1'b0) begin n_fail++;
            $display("FAIL single_rsp got %h id %b want f0f00f0f id 0", bus.rsp_data, bus.rsp_id);
        end
        @(negedge clock);
        n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_c3 got busy %b valid %b want 0/0", bus.busy, bus.rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_data;
        apply_reset();
        bus.req0 = 1'b1; bus.op0 = OpAdd; bus.a0 = 32'd5;      bus.b0 = 32'd7;
        bus.req1 = 1'b1; bus.op1 = OpXor; bus.a1 = 32'hFF00;   bus.b1 = 32'h0FF0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.gnt0 !== (i % 2 == 0) || bus.gnt1 !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL fair_gnt[%0d] got %b%b want %0d", i, bus.gnt0, bus.gnt1, i % 2);
            end
            @(negedge clock);
            @(negedge clock);
            exp_data = (i % 2 == 0) ? 32'd12 : 32'h0000_F0F0;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(i % 2) ||
                            bus.rsp_data !== exp_data) begin n_fail++;
                $display("FAIL fair_rsp[%0d] got v%b id %b %h want v1 id %0d %h",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, i % 2, exp_data);
            end
            @(negedge clock);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.req0 = 1'b1; bus.op0 = OpAnd; bus.a0 = 32'hFFFF_0000; bus.b0 = 32'h0F0F_0F0F;
        bus.req1 = 1'b1; bus.op1 = OpSub; bus.a1 = 32'd10;        bus.b1 = 32'd3;
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++;
            $display("FAIL bp_gnt0 got %b%b want 10", bus.gnt0, bus.gnt1); end
        @(negedge clock);
        bus.req0 = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0F0F_0000 ||
                            bus.rsp_id !== 1'b0 || bus.gnt1 !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold[%0d] got v%b %h id %b gnt1 %b want v1 0f0f0000 id 0 gnt1 0",
                         i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.gnt1);
            end
            @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++;
            $display("FAIL bp_gnt1_in_resp got %b want 0", bus.gnt1); end
        @(negedge clock);
        #1;
        n_checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_fail++;
            $display("FAIL bp_gnt1_idle got %b%b want 01", bus.gnt0, bus.gnt1); end
        @(negedge clock);
        bus.req1 = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.rsp_data !== 32'd7 || bus.rsp_id !== 1'b1) begin n_fail++;
            $display("FAIL bp_rsp1 got %h id %b want 00000007 id 1", bus.rsp_data, bus.rsp_id);
        end
        @(negedge clock);
    endtask

    task automatic test_operand_change();
        bus.req0 = 1'b1; bus.op0 = OpOr; bus.a0 = 32'h1; bus.b0 = 32'h0;
        #1;
        n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++;
            $display("FAIL opchg_gnt0 got %b want 1", bus.gnt0); end
        @(negedge clock);
        bus.a0 = 32'hFFFF_FFFF;
        bus.req0 = 1'b0;
        #1;
        n_checks++; if (bus.alu_a !== 32'h1) begin n_fail++;
            $display("FAIL opchg_alu_a got %h want 00000001", bus.alu_a); end
        @(negedge clock);
        n_checks++; if (bus.rsp_data !== 32'h1 || bus.rsp_id !== 1'b0) begin n_fail++;
            $display("FAIL opchg_rsp got %h id %b want 00000001 id 0", bus.rsp_data, bus.rsp_id);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op();
        // Requester 0 owned the last response, so requester 1 would normally win next
        bus.req1 = 1'b1; bus.op1 = OpAdd; bus.a1 = 32'd2; bus.b1 = 32'd3;
        #1;
        n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++;
            $display("FAIL rmid_gnt1_a got %b want 1", bus.gnt1); end
        @(negedge clock);
        bus.req1 = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'h0)
            begin n_fail++;
            $display("FAIL rmid_exec_abort got busy %b v %b alu_a %h want 0 0 0",
                     bus.busy, bus.rsp_valid, bus.alu_a); end
        bus.req1 = 1'b1;
        #1;
        n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++;
            $display("FAIL rmid_gnt1_b got %b want 1", bus.gnt1); end
        @(negedge clock);
        bus.req1 = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd5) begin n_fail++;
            $display("FAIL rmid_resp got v%b %h want v1 00000005", bus.rsp_valid, bus.rsp_data);
        end
        reset = 1'b1;
        @(negedge clock);
        bus.req0 = 1'b1; bus.op0 = OpOr; bus.a0 = 32'h1234_0000; bus.b0 = 32'h0000_5678;
        bus.req1 = 1'b1;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_data !== 32'h0)
            begin n_fail++;
            $display("FAIL rmid_resp_abort got v%b busy %b %h want 0 0 0",
                     bus.rsp_valid, bus.busy, bus.rsp_data); end
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++;
            $display("FAIL rmid_gnt_in_reset got %b%b want 00", bus.gnt0, bus.gnt1); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++;
            $display("FAIL rmid_first_gnt got %b%b want 10", bus.gnt0, bus.gnt1); end
        @(negedge clock);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.rsp_data !== 32'h1234_5678 || bus.rsp_id !== 1'b0) begin n_fail++;
            $display("FAIL rmid_after_rsp got %h id %b want 12345678 id 0",
                     bus.rsp_data, bus.rsp_id); end
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_operand_change();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one combinational 32-bit ALU datapath (bitwise gates, adder) between two requesters.
- Round-robin arbitration; registers opcode/operands that drive the ALU; captures the ALU result.
- Returns the result on a single response channel using a valid/ready handshake.
- Sits between the register-file/issue logic and the shared ALU instance.

Parameters:
- WIDTH, 32, operand/result width in bits
- OPW, 3, opcode width in bits

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 has an operation pending
- op0  input  OPW  requester 0 opcode
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- req1  input  1  requester 1 has an operation pending
- op1  input  OPW  requester 1 opcode
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- gnt0  output  1  combinational; request 0 accepted this cycle
- gnt1  output  1  combinational; request 1 accepted this cycle
- alu_op  output  OPW  registered opcode driven to the ALU
- alu_a  output  WIDTH  registered operand A driven to the ALU
- alu_b  output  WIDTH  registered operand B driven to the ALU
- alu_result  input  WIDTH  combinational ALU result
- rsp_valid  output  1  response holds a valid result
- rsp_data  output  WIDTH  captured result
- rsp_id  output  1  requester that owns the response
- rsp_ready  input  1  consumer accepts the response
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high; clock and reset as named above.
  - Applies on any clock edge with reset=1 and aborts any in-flight operation; no response is produced for it.
  - State=IDLE; rsp_valid=0, rsp_data=0, rsp_id=0; alu_op/alu_a/alu_b=0; busy=0.
  - last_gnt=1, so requester 0 wins the first contention.
- States: IDLE, EXEC, RESP.
- IDLE:
  - gnt0/gnt1 are combinational, at most one high, and only in IDLE with reset=0.
  - One request only: grant it.
  - Both requests: grant the requester that is not last_gnt.
  - On the grant edge: latch op/a/b of the winner into alu_op/alu_a/alu_b, record owner, go to EXEC.
  - No request: stay in IDLE; ALU regs hold their values.
- EXEC (one cycle):
  - ALU inputs are stable from the registers.
  - On the edge: rsp_data<=alu_result, rsp_id<=owner, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid<=0, last_gnt<=owner, go to IDLE.
  - rsp_ready=0: stay in RESP indefinitely; no new grants.
- gnt0/gnt1 are forced low in EXEC and RESP. Requesters hold req/op/a/b stable until granted.
- Latency: grant in cycle T (IDLE); rsp_valid rises at the start of T+2; rsp_ready in T+2 returns to IDLE at T+3.
- Throughput: at most one operation per 3 cycles.
- Response reflects the grant-time operands; operand changes after the grant edge have no effect.
- rsp_ready while rsp_valid=0 is ignored.
- req deasserted while not granted: silently withdrawn; no state change.
- Arithmetic and width behaviour belong to the ALU; this block passes WIDTH bits unmodified. No truncation or extension.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, no req -> rsp_valid=0, busy=0, gnt0=gnt1=0, alu_a=alu_b=0.
- Single op: req0=1, op0=OR, a0=32'hF0F0_0000, b0=32'h0000_0F0F, rsp_ready=1, ALU model behaves as OR:
  - gnt0=1 in cycle 0
  - rsp_valid=1 in cycle 2 with rsp_data=32'hF0F0_0F0F, rsp_id=0
  - busy=0 in cycle 3
- Contention fairness: req0=req1=1 continuously, rsp_ready=1 -> grants alternate 0,1,0,1 every 3 cycles; first grant to 0; rsp_id sequence 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, req1 pending:
  - rsp_valid and rsp_data held constant; gnt1 stays 0
  - after rsp_ready=1, gnt1 asserts on the following IDLE cycle
- Operand change after grant: a0 changes from 32'h1 to 32'hFFFF_FFFF one cycle after gnt0 -> response uses 32'h1.
- Reset mid-operation: assert reset in EXEC, then in RESP -> next cycle state is IDLE, rsp_valid=0, no response delivered, first subsequent grant goes to requester 0.
